// File: rtl/aes_decr_iter.sv
// Iterative AES-128 decryption core: UNROLL inverse rounds per clock, round keys derived backwards on the fly.
// Optional macro AES_DECR_KEYEXP_EN: key is the cipher key, expanded forward in KEXP with a single-entry k10 cache.
module aes_decr_iter #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
            $error("aes_decr_iter: UNROLL must be 1, 2 or 5");
        end
    endgenerate

    localparam logic [3:0] STEP   = 4'(UNROLL);
    localparam logic [3:0] NROUND = 4'd10;

`ifdef AES_DECR_KEYEXP_EN
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
`endif

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    // k[i] -> k[i-1]
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]   ^ k[63:32];
        w2 = k[63:32]  ^ k[95:64];
        w1 = k[95:64]  ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(i), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // k[i-1] -> k[i]
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(i), 24'h0};
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; column-major, row r of column c is byte r+4c
    function automatic logic [7:0] get_b(input logic [127:0] s, input int unsigned i);
        return 8'(s >> (8 * (15 - i)));
    endfunction

    function automatic logic [127:0] put_b(input logic [7:0] v, input int unsigned i);
        return 128'(v) << (8 * (15 - i));
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o = o | put_b(get_b(s, r + 4 * ((c + 4 - r) % 4)), r + 4 * c);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++)
            o = o | put_b(inv_sbox(get_b(s, i)), i);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = get_b(s, 4 * c);
            a1 = get_b(s, 4 * c + 1);
            a2 = get_b(s, 4 * c + 2);
            a3 = get_b(s, 4 * c + 3);
            o = o
              | put_b(gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09), 4 * c)
              | put_b(gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d), 4 * c + 1)
              | put_b(gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b), 4 * c + 2)
              | put_b(gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e), 4 * c + 3);
        end
        return o;
    endfunction

    // ---------------- registers ----------------
    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] round_st, round_key;

    always_comb begin : round_chain
        logic [127:0] s;
        logic [127:0] k;
        logic [3:0]   r;
        s = st_q;
        k = rk_q;
        r = rnd_q;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            k = inv_key_step(k, r);
            s = inv_sub_bytes(inv_shift_rows(s)) ^ k;
            if (r != 4'd1) s = inv_mix_columns(s);
            r = r - 4'd1;
        end
        round_st  = s;
        round_key = k;
    end

`ifdef AES_DECR_KEYEXP_EN
    logic [127:0] din_q, din_d;
    logic [127:0] ckey_q, ckey_d;
    logic [127:0] ck10_q, ck10_d;
    logic         cvalid_q, cvalid_d;
    logic [127:0] fwd_key;
    logic         key_hit;

    always_comb begin : fwd_chain
        logic [127:0] k;
        logic [3:0]   r;
        k = rk_q;
        r = rnd_q;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            r = r + 4'd1;
            k = fwd_key_step(k, r);
        end
        fwd_key = k;
    end

    assign key_hit = cvalid_q && (key == ckey_q);
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef AES_DECR_KEYEXP_EN
                    state_d = key_hit ? ROUND : KEXP;
`else
                    state_d = ROUND;
`endif
                end
            end
`ifdef AES_DECR_KEYEXP_EN
            KEXP:    if (rnd_q + STEP == NROUND) state_d = ROUND;
`endif
            ROUND:   if (rnd_q == STEP) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state only) ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    assign dout = st_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        st_d  = st_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
`ifdef AES_DECR_KEYEXP_EN
        din_d    = din_q;
        ckey_d   = ckey_q;
        ck10_d   = ck10_q;
        cvalid_d = cvalid_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef AES_DECR_KEYEXP_EN
                    if (key_hit) begin
                        st_d  = din ^ ck10_q;
                        rk_d  = ck10_q;
                        rnd_d = NROUND;
                    end else begin
                        din_d    = din;
                        rk_d     = key;
                        rnd_d    = '0;
                        ckey_d   = key;
                        cvalid_d = 1'b0;
                    end
`else
                    st_d  = din ^ key;
                    rk_d  = key;
                    rnd_d = NROUND;
`endif
                end
            end
`ifdef AES_DECR_KEYEXP_EN
            KEXP: begin
                rk_d  = fwd_key;
                rnd_d = rnd_q + STEP;
                if (rnd_q + STEP == NROUND) begin
                    st_d     = din_q ^ fwd_key;
                    ck10_d   = fwd_key;
                    cvalid_d = 1'b1;
                end
            end
`endif
            ROUND: begin
                st_d  = round_st;
                rk_d  = round_key;
                rnd_d = rnd_q - STEP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
`ifdef AES_DECR_KEYEXP_EN
            din_q    <= '0;
            ckey_q   <= '0;
            ck10_q   <= '0;
            cvalid_q <= 1'b0;
`endif
        end else begin
            st_q  <= st_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
`ifdef AES_DECR_KEYEXP_EN
            din_q    <= din_d;
            ckey_q   <= ckey_d;
            ck10_q   <= ck10_d;
            cvalid_q <= cvalid_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_decr_iter.sv
// Bench for aes_decr_iter: three instances (UNROLL 1, 2, 5) checked against FIPS-197 vectors.
// Honours AES_DECR_KEYEXP_EN: key selection and expected latency follow the build.
module tb_aes_decr_iter;

    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K0_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K0_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv[3], ir[3], ov[3], orr[3], bsy[3];
    logic [127:0] kin[3], dn[3], dq[3];

    aes_decr_iter #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .din(dn[0]), .key(kin[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .dout(dq[0]), .busy(bsy[0]));
    aes_decr_iter #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .din(dn[1]), .key(kin[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .dout(dq[1]), .busy(bsy[1]));
    aes_decr_iter #(.UNROLL(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .din(dn[2]), .key(kin[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .dout(dq[2]), .busy(bsy[2]));

    typedef struct {
        int unsigned  u;
        logic [127:0] k0;
        logic [127:0] k10;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t        vecs[7];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

`ifdef AES_DECR_KEYEXP_EN
    logic [127:0] mc_key[3];
    bit           mc_v[3];
`endif

    function automatic logic [127:0] key_of(input logic [127:0] k0, input logic [127:0] k10);
`ifdef AES_DECR_KEYEXP_EN
        return k0;
`else
        return k10;
`endif
    endfunction

    function automatic int unsigned unr(input int unsigned u);
        case (u)
            0:       return 1;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    // Expected accept-to-out_valid latency, including the key-cache model when KEXP is built
    task automatic model_accept(input int unsigned u, input logic [127:0] k, output int unsigned lat);
        lat = 10 / unr(u);
`ifdef AES_DECR_KEYEXP_EN
        if (!(mc_v[u] && mc_key[u] == k)) begin
            lat       = lat * 2;
            mc_key[u] = k;
            mc_v[u]   = 1'b1;
        end
`endif
    endtask

    task automatic model_reset();
`ifdef AES_DECR_KEYEXP_EN
        for (int i = 0; i < 3; i++) mc_v[i] = 1'b0;
`endif
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic wait_out(input int unsigned u, output int unsigned n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (ov[u]) seen = 1'b1;
        end
    endtask

    task automatic run_block(input int unsigned u, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] pt, input string nm);
        int unsigned lat, n;
        model_accept(u, k, lat);
        @(negedge clk);
        iv[u]  = 1'b1;
        kin[u] = k;
        dn[u]  = ct;
        chk({nm, ".in_ready"}, 128'(ir[u]), 128'd1);
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        wait_out(u, n);
        chk({nm, ".latency"}, 128'(n), 128'(lat));
        chk({nm, ".dout"}, dq[u], pt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, lat, acc, outs, cyc, last;

        vecs[0] = '{0, K0_C1, K10_C1, CT_C1, PT_C1};
        vecs[1] = '{0, K0_C1, K10_C1, CT_C1, PT_C1};
        vecs[2] = '{0, K0_B,  K10_B,  CT_B,  PT_B};
        vecs[3] = '{1, K0_B,  K10_B,  CT_B,  PT_B};
        vecs[4] = '{2, K0_B,  K10_B,  CT_B,  PT_B};
        vecs[5] = '{1, K0_C1, K10_C1, CT_C1, PT_C1};
        vecs[6] = '{2, K0_C1, K10_C1, CT_C1, PT_C1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b1;
            kin[i] = '0;
            dn[i]  = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d.in_ready", i), 128'(ir[i]), 128'd1);
            chk($sformatf("reset%0d.out_valid", i), 128'(ov[i]), 128'd0);
            chk($sformatf("reset%0d.busy", i), 128'(bsy[i]), 128'd0);
            chk($sformatf("reset%0d.dout", i), dq[i], 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_block(vecs[i].u, key_of(vecs[i].k0, vecs[i].k10), vecs[i].ct, vecs[i].pt,
                      $sformatf("vec%0d", i));

        // Back-pressure: hold DONE for 7 cycles, pulse a foreign block meanwhile
        model_accept(0, key_of(K0_C1, K10_C1), lat);
        @(negedge clk);
        orr[0] = 1'b0;
        iv[0]  = 1'b1;
        kin[0] = key_of(K0_C1, K10_C1);
        dn[0]  = CT_C1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        wait_out(0, n);
        chk("bp.latency", 128'(n), 128'(lat));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 3) begin
                iv[0]  = 1'b1;
                kin[0] = key_of(K0_B, K10_B);
                dn[0]  = CT_B;
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d.dout", c), dq[0], PT_C1);
            chk($sformatf("bp%0d.in_ready", c), 128'(ir[0]), 128'd0);
            chk($sformatf("bp%0d.out_valid", c), 128'(ov[0]), 128'd1);
        end
        @(negedge clk);
        iv[0]  = 1'b0;
        orr[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.release_out_valid", 128'(ov[0]), 128'd0);
        chk("bp.release_in_ready", 128'(ir[0]), 128'd1);

        // Reset during the 4th processing cycle after accept
        @(negedge clk);
        iv[0]  = 1'b1;
        kin[0] = key_of(K0_C1, K10_C1);
        dn[0]  = CT_C1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst.busy_before", 128'(bsy[0]), 128'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.busy", 128'(bsy[0]), 128'd0);
        chk("midrst.out_valid", 128'(ov[0]), 128'd0);
        chk("midrst.in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_block(0, key_of(K0_C1, K10_C1), CT_C1, PT_C1, "postrst");

        // Streaming: in_valid held, four blocks, outputs 12 cycles apart
        acc  = 0;
        outs = 0;
        cyc  = 0;
        last = 0;
        kin[0] = key_of(K0_C1, K10_C1);
        dn[0]  = CT_C1;
        while (outs < 4 && cyc < 100) begin
            @(negedge clk);
            if (acc < 4) begin
                iv[0] = 1'b1;
                if (ir[0]) acc++;
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (ov[0]) begin
                outs++;
                chk($sformatf("stream%0d.dout", outs), dq[0], PT_C1);
                if (outs > 1) chk($sformatf("stream%0d.period", outs), 128'(cyc - last), 128'd12);
                last = cyc;
            end
        end
        iv[0] = 1'b0;
        chk("stream.count", 128'(outs), 128'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_decr_iter.md
# aes_decr_iter

Iterative, parametrised AES-128 decryption core, the sequential successor to the fully unrolled ten-round decryption cipher. It implements a configurable number of inverse rounds per clock (`UNROLL`) and derives round keys on the fly by running the key schedule backwards. It has valid/ready handshakes on both sides and sits between the block-level input buffer and the plaintext output stage.

## Interface
- `UNROLL`, default 1: inverse rounds executed per clock. Legal values are 1, 2 and 5; any other value is an elaboration error.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `din`/`key` valid.
- `in_ready` out 1: core can accept a block.
- `din` in 128: ciphertext, byte 0 at [127:120].
- `key` in 128: key input; its meaning depends on the Configuration macro.
- `out_valid` out 1: `dout` valid.
- `out_ready` in 1: downstream accepts `dout`.
- `dout` out 128: plaintext.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, KEXP (present only with the macro), ROUND, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid&&in_ready`, capture `key` and `din`.
  - Without the macro: `st <= din ^ key`, `rk <= key`, `rnd <= 10`, go to ROUND.
- ROUND
  - Each cycle applies `UNROLL` inverse rounds in this order: InvShiftRows, InvSubBytes, AddRoundKey(k[rnd-1]), then InvMixColumns. InvMixColumns is skipped when rnd-1 = 0.
  - `rnd` decrements by `UNROLL`.
  - At `rnd`=0, go to DONE.
- Inverse key step, k[i] → k[i-1], with words w0..w3:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0^SubWord(RotWord(w3'))^Rcon[i]
  - Rcon[10..1] = 36,1b,80,40,20,10,08,04,02,01.
- DONE
  - `out_valid`=1; `dout`=`st`, held stable until `out_ready`.
  - On `out_valid&&out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; no input is captured. `key` is sampled only on the accept cycle.
- `rnd` is a 4-bit counter. It never goes negative because 10 is divisible by every legal `UNROLL`.
- `rst` asserted in any state: the state becomes IDLE and the in-flight block is discarded with no output.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `dout`=0, `st`=0, `rnd`=0.
- Latency: an accept at edge T gives `out_valid`=1 after edge T+10/`UNROLL` (10, 5 or 2 cycles). This excludes KEXP.
- Minimum block period with `out_ready` tied high: 10/`UNROLL`+2 cycles (accept, rounds, DONE, return to IDLE).
- `in_ready` is combinational from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Back-pressure: `out_valid` and `dout` stay stable for as long as `out_ready`=0.

## Configuration
- `AES_DECR_KEYEXP_EN` defined:
  - `key` is the cipher key (round-0 key).
  - On accept, go to KEXP. KEXP forward-expands `UNROLL` rounds per cycle for 10/`UNROLL` cycles, then sets `st <= din_reg ^ k10` and enters ROUND.
  - The computed k10 and the cipher key are cached. If the next accepted `key` equals the cached cipher key, KEXP is skipped.
  - The cache is invalidated on `rst`.
- `AES_DECR_KEYEXP_EN` undefined:
  - `key` must be the round-10 key.
  - KEXP and the cache are not built.

## Test plan
- Macro undefined, `UNROLL`=1: `key`=13111d7fe3944a17f307a78b4d2b30c5, `din`=69c4e0d86a7b0430d8cdb78070b4c55a → `dout`=00112233445566778899aabbccddeeff, with `out_valid` exactly 10 cycles after accept.
- `UNROLL`=2 and `UNROLL`=5: `key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `din`=3925841d02dc09fbdc118597196a0b32 → `dout`=3243f6a8885a308d313198a2e0370734, with latency 5 and 2 cycles respectively.
- Back-pressure: hold `out_ready`=0 for 7 cycles in DONE → `dout` stays constant and `in_ready`=0. Pulse `in_valid` with other data during that time → it is ignored and the result is unchanged.
- Reset mid-operation: assert `rst` on the 4th ROUND cycle → next cycle `busy`=0 and `out_valid`=0. A new block then decrypts correctly.
- Macro defined: cipher key 000102030405060708090a0b0c0d0e0f with the C.1 ciphertext → correct plaintext after 20 cycles (`UNROLL`=1). Same key again → 10 cycles. Key 2b7e151628aed2a6abf7158809cf4f3c → 20 cycles and correct output.
- Streaming, `out_ready`=1: 4 back-to-back C.1 blocks → one output every 12 cycles (`UNROLL`=1), all correct.
